safe_combo_lock: RTL and testbench

SAFE_COMBO_LOCK -- requirements
Module: safe_combo_lock

---
 rtl/safe_pkg.sv | 18 +
 rtl/safe_dial_counter.sv | 27 ++
 rtl/safe_combo_lock.sv | 136 +++++++++++++
 tb/tb_safe_combo_lock.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/safe_pkg.sv
// rtl/safe_pkg.sv - shared state type and default dial/code constants for the combination lock
package safe_pkg;

    localparam int DIAL_MAX_DEF = 39;
    localparam int POS_W_DEF    = 6;
    localparam int CODE0_DEF    = 12;
    localparam int CODE1_DEF    = 30;
    localparam int CODE2_DEF    = 7;

    typedef enum logic [2:0] {
        S0,
        S1,
        S2,
        OPEN,
        LOCKOUT
    } state_t;

endpackage

// File: rtl/safe_dial_counter.sv
// rtl/safe_dial_counter.sv - modulo-(DIAL_MAX+1) up/down dial position counter
module safe_dial_counter
    import safe_pkg::*;
#(
    parameter int DIAL_MAX = DIAL_MAX_DEF,
    parameter int POS_W    = POS_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cnt_n,
    input  logic             up,
    output logic [POS_W-1:0] pos
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos <= '0;
        end else if (!cnt_n) begin
            if (up) begin
                pos <= (pos == POS_W'(DIAL_MAX)) ? '0 : pos + 1'b1;
            end else begin
                pos <= (pos == '0) ? POS_W'(DIAL_MAX) : pos - 1'b1;
            end
        end
    end

endmodule

// File: rtl/safe_combo_lock.sv
// rtl/safe_combo_lock.sv - three-digit dial combination lock FSM; SAFE_LOCKOUT_EN adds failure lockout
module safe_combo_lock
    import safe_pkg::*;
#(
    parameter int DIAL_MAX    = DIAL_MAX_DEF,
    parameter int POS_W       = POS_W_DEF,
    parameter int CODE0       = CODE0_DEF,
    parameter int CODE1       = CODE1_DEF,
    parameter int CODE2       = CODE2_DEF,
    parameter int MAX_FAIL    = 3,
    parameter int LOCKOUT_CYC = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cnt_n,
    input  logic             up,
    input  logic             dirch,
    input  logic             lock_req,
    output logic [POS_W-1:0] pos,
    output logic [1:0]       digit_idx,
    output logic             open,
    output logic             locked_out,
    output logic [1:0]       fail_cnt
);

    state_t           state;
    logic [POS_W-1:0] code_sel;

    safe_dial_counter #(
        .DIAL_MAX (DIAL_MAX),
        .POS_W    (POS_W)
    ) u_dial (
        .clk   (clk),
        .rst   (rst),
        .cnt_n (cnt_n),
        .up    (up),
        .pos   (pos)
    );

    always_comb begin
        code_sel = '0;
        case (state)
            S0:      code_sel = POS_W'(CODE0);
            S1:      code_sel = POS_W'(CODE1);
            S2:      code_sel = POS_W'(CODE2);
            default: code_sel = '0;
        endcase
    end

`ifdef SAFE_LOCKOUT_EN
    localparam int LW = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;
    logic [LW-1:0] lock_cnt;
    logic [2:0]    fail_next;
    assign fail_next = {1'b0, fail_cnt} + 3'd1;
`else
    assign locked_out = 1'b0;
    assign fail_cnt   = 2'b00;
`endif

    // pos is compared as registered, so a same-cycle count strobe cannot disturb the capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S0;
            digit_idx <= 2'd0;
            open      <= 1'b0;
`ifdef SAFE_LOCKOUT_EN
            locked_out <= 1'b0;
            fail_cnt   <= 2'd0;
            lock_cnt   <= '0;
`endif
        end else begin
            case (state)
                S0, S1, S2: begin
                    if (dirch) begin
                        if (pos == code_sel) begin
                            case (state)
                                S0: begin
                                    state     <= S1;
                                    digit_idx <= 2'd1;
                                end
                                S1: begin
                                    state     <= S2;
                                    digit_idx <= 2'd2;
                                end
                                default: begin
                                    state     <= OPEN;
                                    digit_idx <= 2'd3;
                                    open      <= 1'b1;
`ifdef SAFE_LOCKOUT_EN
                                    fail_cnt  <= 2'd0;
`endif
                                end
                            endcase
                        end else begin
                            state     <= S0;
                            digit_idx <= 2'd0;
`ifdef SAFE_LOCKOUT_EN
                            if (fail_next == 3'(MAX_FAIL)) begin
                                state      <= LOCKOUT;
                                locked_out <= 1'b1;
                                fail_cnt   <= 2'd0;
                                lock_cnt   <= LW'(LOCKOUT_CYC - 1);
                            end else begin
                                fail_cnt <= fail_next[1:0];
                            end
`endif
                        end
                    end
                end
                OPEN: begin
                    if (lock_req) begin
                        state     <= S0;
                        digit_idx <= 2'd0;
                        open      <= 1'b0;
                    end
                end
`ifdef SAFE_LOCKOUT_EN
                LOCKOUT: begin
                    if (lock_cnt == '0) begin
                        state      <= S0;
                        locked_out <= 1'b0;
                    end else begin
                        lock_cnt <= lock_cnt - 1'b1;
                    end
                end
`endif
                default: begin
                    state     <= S0;
                    digit_idx <= 2'd0;
                    open      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_safe_combo_lock.sv
// tb/tb_safe_combo_lock.sv - directed plus randomized checks of safe_combo_lock against a behavioural model
module tb_safe_combo_lock;

    localparam int DIAL_MAX = 39;
    localparam int NPOS     = DIAL_MAX + 1;
    localparam int LCYC     = 20;
    localparam int MAXF     = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cnt_n = 1'b1;
    logic       up = 1'b0;
    logic       dirch = 1'b0;
    logic       lock_req = 1'b0;
    logic [5:0] pos;
    logic [1:0] digit_idx;
    logic       open;
    logic       locked_out;
    logic [1:0] fail_cnt;

    int vectors = 0;
    int miscompares = 0;

    int codes [3] = '{12, 30, 7};
    int m_pos, m_digits, m_fail, m_lock;

    safe_combo_lock #(.LOCKOUT_CYC(LCYC)) dut (
        .clk        (clk),
        .rst        (rst),
        .cnt_n      (cnt_n),
        .up         (up),
        .dirch      (dirch),
        .lock_req   (lock_req),
        .pos        (pos),
        .digit_idx  (digit_idx),
        .open       (open),
        .locked_out (locked_out),
        .fail_cnt   (fail_cnt)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_pos = 0; m_digits = 0; m_fail = 0; m_lock = 0;
    endtask

    // m_digits counts accepted digits (3 = open); m_lock counts remaining lockout cycles
    task automatic model_edge(input logic c_n, input logic u, input logic d, input logic l);
        int seen;
        seen = m_pos;
        if (!c_n) m_pos = u ? (m_pos + 1) % NPOS : (m_pos + NPOS - 1) % NPOS;
        if (m_lock > 0) begin
            m_lock--;
        end else if (m_digits == 3) begin
            if (l) m_digits = 0;
        end else if (d) begin
            if (seen == codes[m_digits]) begin
                m_digits++;
                if (m_digits == 3) m_fail = 0;
            end else begin
                m_digits = 0;
`ifdef SAFE_LOCKOUT_EN
                m_fail++;
                if (m_fail == MAXF) begin
                    m_fail = 0;
                    m_lock = LCYC;
                end
`endif
            end
        end
    endtask

    task automatic check_outs(input string tag);
        vectors++;
        assert (pos === 6'(m_pos)) else begin
            miscompares++;
            $error("FAIL %s pos observed=%0d expected=%0d", tag, pos, m_pos);
        end
        assert (digit_idx === 2'(m_digits)) else begin
            miscompares++;
            $error("FAIL %s digit_idx observed=%0d expected=%0d", tag, digit_idx, m_digits);
        end
        assert (open === (m_digits == 3)) else begin
            miscompares++;
            $error("FAIL %s open observed=%0b expected=%0b", tag, open, m_digits == 3);
        end
        assert (locked_out === (m_lock > 0)) else begin
            miscompares++;
            $error("FAIL %s locked_out observed=%0b expected=%0b", tag, locked_out, m_lock > 0);
        end
        assert (fail_cnt === 2'(m_fail)) else begin
            miscompares++;
            $error("FAIL %s fail_cnt observed=%0d expected=%0d", tag, fail_cnt, m_fail);
        end
    endtask

    // called at a falling edge; returns at the next falling edge
    task automatic step(input logic c_n, input logic u, input logic d, input logic l, input string tag);
        cnt_n = c_n; up = u; dirch = d; lock_req = l;
        @(posedge clk);
        model_edge(c_n, u, d, l);
        #1;
        check_outs(tag);
        @(negedge clk);
        cnt_n = 1'b1; dirch = 1'b0; lock_req = 1'b0;
    endtask

    task automatic spin_to(input int target, input logic u, input string tag);
        for (int i = 0; i < NPOS && m_pos != target; i++) step(1'b0, u, 1'b0, 1'b0, tag);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        #1;
        check_outs("reset");
        @(negedge clk);
        rst = 1'b0;

        step(1'b0, 1'b0, 1'b0, 1'b0, "wrap_dec");
        step(1'b0, 1'b1, 1'b0, 1'b0, "wrap_inc");

        spin_to(12, 1'b1, "entry_d0");
        step(1'b1, 1'b0, 1'b1, 1'b0, "accept_d0");
        spin_to(30, 1'b0, "entry_d1");
        step(1'b1, 1'b0, 1'b1, 1'b0, "accept_d1");
        spin_to(7, 1'b1, "entry_d2");
        step(1'b1, 1'b0, 1'b1, 1'b0, "accept_open");
        step(1'b1, 1'b0, 1'b1, 1'b0, "open_ignores_dirch");
        step(1'b1, 1'b0, 1'b0, 1'b1, "relock");

        spin_to(13, 1'b1, "to_13");
        step(1'b1, 1'b0, 1'b1, 1'b0, "mismatch1");
        step(1'b1, 1'b0, 1'b1, 1'b0, "mismatch2");
        step(1'b1, 1'b0, 1'b1, 1'b0, "mismatch3");
        for (int i = 0; i < LCYC + 2; i++) step(1'b0, 1'(i % 2), 1'b1, 1'b1, "lockout_window");

        spin_to(12, 1'b0, "to_12");
        step(1'b0, 1'b1, 1'b1, 1'b0, "simultaneous");
        spin_to(30, 1'b0, "to_30");
        step(1'b1, 1'b0, 1'b1, 1'b0, "reach_s2");
        spin_to(25, 1'b0, "to_25");
        rst = 1'b1;
        #1;
        model_reset();
        check_outs("async_reset");
        @(negedge clk);
        rst = 1'b0;

        spin_to(12, 1'b1, "re_d0");
        step(1'b1, 1'b0, 1'b1, 1'b0, "re_accept_d0");
        spin_to(30, 1'b0, "re_d1");
        step(1'b1, 1'b0, 1'b1, 1'b0, "re_accept_d1");
        spin_to(7, 1'b1, "re_d2");
        step(1'b1, 1'b0, 1'b1, 1'b0, "re_open");
        step(1'b1, 1'b0, 1'b0, 1'b1, "re_relock");

        spin_to(5, 1'b0, "to_5");
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 1'b0, "five_mismatch");

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) < 4) begin
                int tgt;
                tgt = ($urandom_range(0, 1) == 1 && m_digits < 3) ? codes[m_digits]
                                                                  : int'($urandom_range(0, DIAL_MAX));
                spin_to(tgt, 1'($urandom_range(0, 1)), "rnd_spin");
                step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1,
                     1'($urandom_range(0, 3) == 0), "rnd_dirch");
            end else begin
                step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) == 0), "rnd_step");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
